// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, cell-grid defaults and bus widths.
// Also used by background_generator (COLOR_W).
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HW = 10;
    localparam int VW = 10;

    localparam int H_CELLS_DEF = 120;
    localparam int V_CELLS_DEF = 68;
    localparam int CELL_W_DEF  = 5;
    localparam int CELL_H_DEF  = 7;
    localparam int H_OFF_DEF   = 20;
    localparam int V_OFF_DEF   = 2;

    localparam int ADDR_W  = 13;
    localparam int COLOR_W = 6;

endpackage

// File: rtl/vga_cell_scanner_if.sv
// Scan output bundle: cell address (1 cycle after counters) and colour-aligned
// sync/blank/grid flags (2 cycles after counters). No backpressure.
interface vga_cell_scanner_if;
    import vga_pkg::*;

    logic [ADDR_W-1:0] o_address;
    logic              o_hsync;
    logic              o_vsync;
    logic              o_active;
    logic              o_grid;
    logic              o_frame_start;

    modport master (
        output o_address,
        output o_hsync,
        output o_vsync,
        output o_active,
        output o_grid,
        output o_frame_start
    );

    modport slave (
        input o_address,
        input o_hsync,
        input o_vsync,
        input o_active,
        input o_grid,
        input o_frame_start
    );

endinterface

// File: rtl/vga_timing_counter.sv
// Free-running h/v scan counters with combinational sync/active/frame decode.
// Latency 0 on the decode; no backpressure.
module vga_timing_counter
    import vga_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          hsync_raw,
    output logic          vsync_raw,
    output logic          active_raw,
    output logic          frame_start_raw
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == HW'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign hsync_raw = !((h >= HW'(H_ACTIVE + H_FP)) &&
                         (h <  HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vsync_raw = !((v >= VW'(V_ACTIVE + V_FP)) &&
                         (v <  VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign active_raw      = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    assign frame_start_raw = (h == '0) && (v == '0);

endmodule

// File: rtl/vga_cell_scanner.sv
// VGA scan timing plus incremental cell address; address 1 cycle, flags 2 cycles after counters.
// No backpressure: free-running scan.
module vga_cell_scanner
    import vga_pkg::*;
#(
    parameter int H_CELLS = H_CELLS_DEF,
    parameter int V_CELLS = V_CELLS_DEF,
    parameter int CELL_W  = CELL_W_DEF,
    parameter int CELL_H  = CELL_H_DEF,
    parameter int H_OFF   = H_OFF_DEF,
    parameter int V_OFF   = V_OFF_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    vga_cell_scanner_if.master  scan
);

    localparam int H_END = H_OFF + H_CELLS * CELL_W;
    localparam int V_END = V_OFF + V_CELLS * CELL_H;
    localparam int PXW   = $clog2(CELL_W + 1);
    localparam int COLW  = $clog2(H_CELLS + 1);
    localparam int LNW   = $clog2(CELL_H + 1);
    localparam int ROWW  = $clog2(V_CELLS + 1);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          hsync_raw;
    logic          vsync_raw;
    logic          active_raw;
    logic          frame_start_raw;

    vga_timing_counter u_timing (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .h               (h),
        .v               (v),
        .hsync_raw       (hsync_raw),
        .vsync_raw       (vsync_raw),
        .active_raw      (active_raw),
        .frame_start_raw (frame_start_raw)
    );

    logic [PXW-1:0]    px;
    logic [COLW-1:0]   col;
    logic [LNW-1:0]    ln;
    logic [ROWW-1:0]   row;
    logic [ADDR_W-1:0] row_base;

    logic h_in;
    logic v_in;
    logic in_win;
    logic line_end;

    assign h_in     = (h >= HW'(H_OFF)) && (h < HW'(H_END));
    assign v_in     = (v >= VW'(V_OFF)) && (v < VW'(V_END));
    assign in_win   = h_in && v_in;
    assign line_end = (h == HW'(H_TOTAL - 1));

    // Cell state is re-armed one pixel/line before the grid, so no stale value can leak in.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            px       <= '0;
            col      <= '0;
            ln       <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            if (h == HW'(H_OFF - 1)) begin
                px  <= '0;
                col <= '0;
            end else if (in_win) begin
                if (px == PXW'(CELL_W - 1)) begin
                    px  <= '0;
                    col <= (col == COLW'(H_CELLS - 1)) ? '0 : col + 1'b1;
                end else begin
                    px <= px + 1'b1;
                end
            end

            if (line_end) begin
                if (v == VW'(V_OFF - 1)) begin
                    ln       <= '0;
                    row      <= '0;
                    row_base <= '0;
                end else if (v_in) begin
                    if (ln == LNW'(CELL_H - 1)) begin
                        ln <= '0;
                        if (row == ROWW'(V_CELLS - 1)) begin
                            row      <= '0;
                            row_base <= '0;
                        end else begin
                            row      <= row + 1'b1;
                            row_base <= row_base + ADDR_W'(H_CELLS);
                        end
                    end else begin
                        ln <= ln + 1'b1;
                    end
                end
            end
        end
    end

    logic s1_hsync;
    logic s1_vsync;
    logic s1_active;
    logic s1_grid;
    logic s1_frame_start;

    // Stage 1 lines up with the address; stage 2 lines up with background_generator's colour.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            scan.o_address     <= '0;
            s1_hsync           <= 1'b1;
            s1_vsync           <= 1'b1;
            s1_active          <= 1'b0;
            s1_grid            <= 1'b0;
            s1_frame_start     <= 1'b0;
            scan.o_hsync       <= 1'b1;
            scan.o_vsync       <= 1'b1;
            scan.o_active      <= 1'b0;
            scan.o_grid        <= 1'b0;
            scan.o_frame_start <= 1'b0;
        end else begin
            scan.o_address     <= in_win ? row_base + ADDR_W'(col) : '0;
            s1_hsync           <= hsync_raw;
            s1_vsync           <= vsync_raw;
            s1_active          <= active_raw;
            s1_grid            <= in_win;
            s1_frame_start     <= frame_start_raw;
            scan.o_hsync       <= s1_hsync;
            scan.o_vsync       <= s1_vsync;
            scan.o_active      <= s1_active;
            scan.o_grid        <= s1_grid;
            scan.o_frame_start <= s1_frame_start;
        end
    end

endmodule
